// File: rtl/sc_window_counter_pkg.sv
// Shared stochastic-computing package: types common to the SC blocks.
// Only width-independent items live here; anything derived from WIDTH
// stays inside the modules that own the parameter.
package sc_window_counter_pkg;

  // Window-counter control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } sc_state_e;

endpackage : sc_window_counter_pkg

// File: rtl/sc_window_counter_if.sv
// Handshake bundle for the window counter: start, bitstream input with
// valid/ready, and the result channel with valid/ready.
interface sc_window_counter_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             in;
  logic             in_valid;
  logic             in_ready;
  logic             busy;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH:0]   out_uni;
  logic [WIDTH+1:0] out_bip;

  // Producer/consumer side
  modport master (
    output start, in, in_valid, out_ready,
    input  in_ready, busy, out_valid, out_uni, out_bip
  );

  // Counter side
  modport slave (
    input  start, in, in_valid, out_ready,
    output in_ready, busy, out_valid, out_uni, out_bip
  );
endinterface : sc_window_counter_if

// File: rtl/sc_window_timer.sv
// Sample counter for one window. Counts enabled cycles; WIDTH+1 bits so
// that N itself is representable. 'last' marks the enabled cycle that
// delivers the Nth sample.
module sc_window_timer #(
  parameter int WIDTH = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           enable,
  output logic [WIDTH:0] count,
  output logic           last
);

  localparam logic [WIDTH:0] N_MINUS_1 = {1'b0, {WIDTH{1'b1}}};

  logic [WIDTH:0] count_r;

  // Sample counter: reset/clear win over enable
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r <= '0;
    end else if (clear) begin
      count_r <= '0;
    end else if (enable) begin
      count_r <= count_r + {{WIDTH{1'b0}}, 1'b1};
    end else begin
      count_r <= count_r;
    end
  end

  assign count = count_r;
  assign last  = enable && (count_r == N_MINUS_1);

endmodule : sc_window_timer

// File: rtl/sc_window_counter.sv
// Stochastic-bitstream window counter: counts the 1-bits in a window of
// N = 2^WIDTH accepted samples and presents the result as an unsigned
// count and as a bipolar value 2*ones - N.
module sc_window_counter
  import sc_window_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic                clk,
  input logic                rst,
  sc_window_counter_if.slave bus
);

  // N sign-extended into the bipolar width
  localparam logic [WIDTH+1:0] N_EXT = {2'b01, {WIDTH{1'b0}}};

  sc_state_e      state_r;
  logic [WIDTH:0] ones_r;
  logic           in_ready_r;
  logic           busy_r;
  logic           out_valid_r;

  logic           accept_s;
  logic           clear_s;
  logic           last_s;
  logic [WIDTH:0] count_s;
  logic           unused_count_s;

  // Accept qualifier and window-open (counter clear) decode
  always_comb begin
    accept_s = bus.in_valid & in_ready_r;
    clear_s  = 1'b0;
    case (state_r)
      ST_IDLE:  clear_s = bus.start;
      ST_DONE:  clear_s = bus.start & bus.out_ready;
      default:  clear_s = 1'b0;
    endcase
  end

  sc_window_timer #(.WIDTH(WIDTH)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (clear_s),
    .enable (accept_s),
    .count  (count_s),
    .last   (last_s)
  );

  // The timer's running count is only needed for its 'last' decode
  assign unused_count_s = ^count_s;

  // Control FSM with registered status flags and the ones accumulator
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      ones_r      <= '0;
      in_ready_r  <= 1'b0;
      busy_r      <= 1'b0;
      out_valid_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.start) begin
            state_r     <= ST_ACCUM;
            ones_r      <= '0;
            in_ready_r  <= 1'b1;
            busy_r      <= 1'b1;
            out_valid_r <= 1'b0;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ACCUM: begin
          // start is deliberately ignored while a window is running
          if (accept_s) begin
            ones_r <= ones_r + {{WIDTH{1'b0}}, bus.in};
            if (last_s) begin
              state_r     <= ST_DONE;
              in_ready_r  <= 1'b0;
              out_valid_r <= 1'b1;
            end else begin
              state_r <= ST_ACCUM;
            end
          end else begin
            state_r <= ST_ACCUM;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            if (bus.start) begin
              // back-to-back window, no idle bubble
              state_r    <= ST_ACCUM;
              ones_r     <= '0;
              in_ready_r <= 1'b1;
              busy_r     <= 1'b1;
            end else begin
              state_r    <= ST_IDLE;
              in_ready_r <= 1'b0;
              busy_r     <= 1'b0;
            end
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          ones_r      <= '0;
          in_ready_r  <= 1'b0;
          busy_r      <= 1'b0;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.busy      = busy_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_uni   = ones_r;
  assign bus.out_bip   = {ones_r, 1'b0} - N_EXT;

endmodule : sc_window_counter

// File: tb/tb_sc_window_counter.sv
// Self-checking bench for sc_window_counter (WIDTH=4, N=16): directed
// windows followed by randomized traffic, compared every cycle against a
// behavioural model that keeps the accepted bits of the window in a queue.
module tb_sc_window_counter;

  localparam int W = 4;
  localparam int N = 16;

  logic clk;
  logic rst;

  sc_window_counter_if #(.WIDTH(W)) bus ();

  sc_window_counter #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // behavioural model: window open, result pending, accepted bits so far
  bit m_open = 1'b0;
  bit m_done = 1'b0;
  bit m_bits[$];

  task automatic chk(input string tag, input int obs, input int exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int m_ones();
    int s = 0;
    foreach (m_bits[i]) s += int'(m_bits[i]);
    return s;
  endfunction

  task automatic model_update(input bit st, input bit b, input bit v,
                              input bit ordy, input bit r);
    if (r) begin
      m_open = 1'b0;
      m_done = 1'b0;
      m_bits.delete();
    end else if (m_done) begin
      if (ordy) begin
        m_done = 1'b0;
        m_open = st;
        if (st) m_bits.delete();
      end
    end else if (m_open) begin
      if (v) begin
        m_bits.push_back(b);
        if (m_bits.size() == N) begin
          m_open = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (st) begin
      m_open = 1'b1;
      m_bits.delete();
    end
  endtask

  task automatic check_outputs();
    chk("in_ready",  int'(bus.in_ready),  int'(m_open));
    chk("busy",      int'(bus.busy),      int'(m_open | m_done));
    chk("out_valid", int'(bus.out_valid), int'(m_done));
    chk("out_uni",   int'(bus.out_uni),   m_ones());
    chk("out_bip",   int'($signed(bus.out_bip)), 2 * m_ones() - N);
  endtask

  // drive at negedge, let the edge happen, check at the following negedge
  task automatic step(input bit st, input bit b, input bit v,
                      input bit ordy, input bit r);
    bus.start     = st;
    bus.in        = b;
    bus.in_valid  = v;
    bus.out_ready = ordy;
    rst           = r;
    @(posedge clk);
    model_update(st, b, v, ordy, r);
    @(negedge clk);
    check_outputs();
  endtask

  initial begin
    int k;
    bus.start = 1'b0; bus.in = 1'b0; bus.in_valid = 1'b0;
    bus.out_ready = 1'b0; rst = 1'b1;
    @(negedge clk);

    // reset state
    step(0, 0, 0, 0, 1);
    chk("rst_valid", int'(bus.out_valid), 0);
    chk("rst_bip", int'($signed(bus.out_bip)), -N);

    // sixteen ones
    step(1, 0, 0, 0, 0);
    chk("start_ready", int'(bus.in_ready), 1);
    repeat (N) step(0, 1, 1, 0, 0);
    chk("ones_valid", int'(bus.out_valid), 1);
    chk("ones_uni", int'(bus.out_uni), 16);
    chk("ones_bip", int'($signed(bus.out_bip)), 16);
    step(0, 0, 0, 1, 0);

    // sixteen zeros
    step(1, 0, 0, 0, 0);
    repeat (N) step(0, 0, 1, 0, 0);
    chk("zeros_uni", int'(bus.out_uni), 0);
    chk("zeros_bip", int'($signed(bus.out_bip)), -16);
    step(0, 0, 0, 1, 0);

    // alternating 1/0
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, (i % 2) == 0, 1, 0, 0);
    chk("alt_uni", int'(bus.out_uni), 8);
    chk("alt_bip", int'($signed(bus.out_bip)), 0);
    step(0, 0, 0, 1, 0);

    // ten ones, in_valid low every other cycle
    step(1, 0, 0, 0, 0);
    k = 0;
    for (int i = 0; i < 2 * N; i++) begin
      if ((i % 2) == 0) begin
        step(0, k < 10, 1, 0, 0);
        k++;
      end else begin
        step(0, 1, 0, 0, 0);
      end
    end
    chk("gap_valid", int'(bus.out_valid), 1);
    chk("gap_uni", int'(bus.out_uni), 10);
    chk("gap_bip", int'($signed(bus.out_bip)), 4);
    step(0, 0, 0, 1, 0);

    // twelve ones, result held with out_ready low and start pulses ignored
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < N; i++) step(0, i < 12, 1, 0, 0);
    for (int i = 0; i < 5; i++) begin
      step((i % 2) == 0, 1, 1, 0, 0);
      chk("hold_uni", int'(bus.out_uni), 12);
      chk("hold_ready", int'(bus.in_ready), 0);
    end
    step(0, 0, 0, 1, 0);

    // reset mid-window, then a fresh window of zeros
    step(1, 0, 0, 0, 0);
    repeat (7) step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 1);
    chk("midrst_busy", int'(bus.busy), 0);
    chk("midrst_uni", int'(bus.out_uni), 0);
    step(1, 0, 0, 0, 0);
    repeat (N) step(0, 0, 1, 0, 0);
    chk("fresh_uni", int'(bus.out_uni), 0);

    // back-to-back window from DONE
    step(1, 0, 0, 1, 0);
    chk("b2b_ready", int'(bus.in_ready), 1);
    chk("b2b_valid", int'(bus.out_valid), 0);
    repeat (N) step(0, 1, 1, 0, 0);
    chk("b2b_uni", int'(bus.out_uni), 16);
    step(0, 0, 0, 1, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) == 0, $urandom % 2, ($urandom % 4) != 0,
           $urandom % 2, ($urandom % 200) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_sc_window_counter

// File: doc/sc_window_counter.md
SC_WINDOW_COUNTER -- requirements
Module: sc_window_counter

Interface
REQ-001 Parameter WIDTH, default 8: log2 of the window length; the window length N = 2^WIDTH bits.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  pulse that opens a new counting window; honoured only in IDLE, or in DONE together with out_ready.
REQ-005 in  input  1  stochastic bitstream bit, e.g. the output of the square-root stage.
REQ-006 in_valid  input  1  qualifies in; in is counted only when in_valid and in_ready are both 1.
REQ-007 in_ready  output  1  high exactly in state ACCUM.
REQ-008 busy  output  1  high in ACCUM and DONE.
REQ-009 out_valid  output  1  high exactly in state DONE.
REQ-010 out_ready  input  1  consumer accept; a transfer occurs when out_valid and out_ready are both 1.
REQ-011 out_uni  output  WIDTH+1  unsigned count of 1-bits in the window, range 0..N.
REQ-012 out_bip  output  WIDTH+2  signed bipolar value 2*out_uni - N, range -N..+N.

Function
REQ-013 The state machine SHALL have three states: IDLE, ACCUM and DONE.
REQ-014 IDLE: when start=1, the next state SHALL be ACCUM, with the ones counter and the sample counter both cleared to 0; otherwise the block stays in IDLE.
REQ-015 ACCUM: on each accepted bit the sample counter SHALL increment by 1 and the ones counter SHALL add in.
REQ-016 ACCUM: cycles with in_valid=0 SHALL change neither counter.
REQ-017 When the accepted bit is the Nth of the window, the next state SHALL be DONE; out_valid SHALL rise on the cycle after that Nth bit is accepted.
REQ-018 The sample counter SHALL be WIDTH+1 bits wide, so that the value N is representable and no wrap-around occurs within a window.
REQ-019 The ones counter SHALL saturate at no point; its maximum reachable value is N.
REQ-020 start SHALL be ignored in ACCUM; the window in progress continues unaffected.
REQ-021 DONE: out_uni and out_bip SHALL hold the final count and stay stable until the transfer.
REQ-022 DONE: in_ready=0, so upstream is back-pressured.
REQ-023 DONE with out_ready=1 and start=0: the next state SHALL be IDLE.
REQ-024 DONE with out_ready=1 and start=1: the next state SHALL be ACCUM with both counters cleared (back-to-back windows, no idle cycle).
REQ-025 DONE with out_ready=0: the block SHALL stay in DONE regardless of start.
REQ-026 out_bip SHALL be computed combinationally from the ones register as (ones << 1) - N, in WIDTH+2-bit two's complement.
REQ-027 Outside DONE, out_uni and out_bip SHALL show the current ones-counter contents; consumers must not rely on them while out_valid=0.

Reset
REQ-028 rst=1 SHALL force state IDLE and clear the ones and sample counters on the same edge, from any state including mid-window.
REQ-029 After reset: in_ready=0, busy=0, out_valid=0, out_uni=0, out_bip=-N.
REQ-030 A window interrupted by reset SHALL produce no output; the next start SHALL begin a fresh window.

Structure
REQ-031 The state enum type SHALL live in the shared stochastic-computing package.
REQ-032 No widths or constants that depend on WIDTH SHALL be placed in the shared package.
REQ-033 The sample counter SHALL be a separate sub-module, sc_window_timer: clear, enable, WIDTH+1-bit count, and a last flag that is high when the count equals N-1 and enable=1.
REQ-034 The datapath and FSM SHALL remain in sc_window_counter; no other sub-modules.

Verification (WIDTH=4, N=16)
REQ-035 Reset, then start, then 16 accepted ones -> out_valid on the cycle after the 16th bit, out_uni=16, out_bip=+16.
REQ-036 Sixteen accepted zeros -> out_uni=0, out_bip=-16; alternating 1/0 -> out_uni=8, out_bip=0.
REQ-037 Ten ones delivered with in_valid low on every other cycle -> done after 16 accepted bits (about 32 cycles), out_uni=10, out_bip=+4.
REQ-038 Window of 12 ones, out_ready held low 5 cycles -> out_uni=12 stable and in_ready=0 throughout; start pulses during the hold are ignored.
REQ-039 rst asserted after 7 accepted bits -> next cycle IDLE with all outputs at reset values; a new start followed by 16 zeros -> out_uni=0.
REQ-040 In DONE, out_ready=1 together with start=1 -> next cycle ACCUM with in_ready=1, and the next window counts from 0 (16 ones -> 16).
